// File: rtl/inference_stats_pkg.sv
// Shared types and helpers for the inference accuracy scoreboard.
// Width helpers keep the top and its divider in agreement about result sizes.
package inference_stats_pkg;

  // Widest one-hot vector the helpers below accept; narrower vectors are zero-extended.
  localparam int MAX_CLASSES = 64;
  localparam logic [MAX_CLASSES-1:0] ONE_VEC = MAX_CLASSES'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic int calc_cnt_w(input int max_inputs);
    return $clog2(max_inputs + 1);
  endfunction

  function automatic int calc_acc_w(input int frac_bits);
    return 7 + frac_bits;
  endfunction

  function automatic int calc_div_w(input int cnt_w, input int frac_bits);
    return cnt_w + 7 + frac_bits;
  endfunction

  function automatic logic is_onehot(input logic [MAX_CLASSES-1:0] v);
    return (v != '0) && ((v & (v - ONE_VEC)) == '0);
  endfunction

  function automatic int onehot_to_index(input logic [MAX_CLASSES-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CLASSES; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first bit is produced on the start edge, so done_o rises DVD_W-1 cycles after start.
module seq_divider #(
  parameter int DVD_W = 15,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o,
  output logic [DVS_W-1:0] remainder_o
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, rem_d, src_rem;
  logic [DVD_W-1:0] quo_q, quo_d, src_quo;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DVS_W:0]   shifted;
  logic             ge;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    shifted = {src_rem, src_quo[DVD_W-1]};
    ge      = shifted >= {1'b0, divisor_i};

    if (start_i || busy_q) begin
      // The remainder stays below the divisor, so the restored value always fits DVS_W bits.
      rem_d  = ge ? DVS_W'(shifted - {1'b0, divisor_i}) : shifted[DVS_W-1:0];
      quo_d  = {src_quo[DVD_W-2:0], ge};
      cnt_d  = start_i ? CW'(DVD_W - 1) : cnt_q - CW'(1);
      busy_d = (cnt_d != '0);
      done_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/inference_scoreboard.sv
// Scores each inference result against its label and keeps running accuracy statistics.
// One result is accepted at a time; the accuracy division runs before the next is taken.
module inference_scoreboard
  import inference_stats_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int MAX_INPUTS  = 200,
  parameter int FRAC_BITS   = 0,
  parameter int CNT_W       = calc_cnt_w(MAX_INPUTS),
  parameter int ACC_W       = calc_acc_w(FRAC_BITS),
  parameter int SEL_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst_overall,
  input  logic                   clear,
  input  logic                   result_valid,
  output logic                   result_ready,
  input  logic [NUM_CLASSES-1:0] obtained_output,
  input  logic [NUM_CLASSES-1:0] expected_output,
  output logic [CNT_W-1:0]       count,
  output logic [CNT_W-1:0]       correct_count,
  output logic [CNT_W-1:0]       invalid_count,
  output logic [ACC_W-1:0]       accuracy,
  output logic                   accuracy_valid,
  output logic                   overrun,
  output logic                   all_done,
  input  logic [SEL_W-1:0]       class_sel,
  output logic [CNT_W-1:0]       class_seen,
  output logic [CNT_W-1:0]       class_hits
);

  localparam int DW = calc_div_w(CNT_W, FRAC_BITS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic [CNT_W-1:0] invalid_q, invalid_d;
  logic [ACC_W-1:0] accuracy_q, accuracy_d;
  logic             acc_valid_q, acc_valid_d;
  logic             overrun_q, overrun_d;
  logic             all_done_q, all_done_d;
  logic [CNT_W-1:0] seen_q [NUM_CLASSES];
  logic [CNT_W-1:0] hits_q [NUM_CLASSES];

  logic             flush;
  logic             accept;
  logic             obt_ok, exp_ok, hit;
  int               exp_idx;

  logic [DW-1:0]    dividend;
  logic [DW-1:0]    quotient;
  logic             div_done;
  logic             div_busy_unused;
  logic [CNT_W-1:0] div_rem_unused;
  logic             quo_high_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(MAX_INPUTS)) ? v : v + CNT_W'(1);
  endfunction

  assign flush        = rst_overall | clear;
  assign result_ready = (state_q == ST_IDLE) && !all_done_q;
  assign accept       = result_valid && result_ready;

  assign obt_ok  = is_onehot(MAX_CLASSES'(obtained_output));
  assign exp_ok  = is_onehot(MAX_CLASSES'(expected_output));
  assign hit     = obt_ok && exp_ok && (obtained_output == expected_output);
  assign exp_idx = onehot_to_index(MAX_CLASSES'(expected_output));

  // Counters already hold the new totals in LOAD, so the divider sees this result included.
  assign dividend = (DW'(correct_q) * DW'(100)) << FRAC_BITS;

  seq_divider #(
    .DVD_W(DW),
    .DVS_W(CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_i      (flush),
    .start_i    (state_q == ST_LOAD),
    .dividend_i (dividend),
    .divisor_i  (count_q),
    .busy_o     (div_busy_unused),
    .done_o     (div_done),
    .quotient_o (quotient),
    .remainder_o(div_rem_unused)
  );

  // Quotient never exceeds 100 << FRAC_BITS, so bits above ACC_W are always zero.
  assign quo_high_unused = ^quotient[DW-1:ACC_W];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    correct_d   = correct_q;
    invalid_d   = invalid_q;
    accuracy_d  = accuracy_q;
    acc_valid_d = 1'b0;
    overrun_d   = overrun_q;
    all_done_d  = all_done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_LOAD;
          count_d    = sat_inc(count_q);
          if (hit) correct_d = sat_inc(correct_q);
          if (!(obt_ok && exp_ok)) invalid_d = sat_inc(invalid_q);
          all_done_d = (count_d == CNT_W'(MAX_INPUTS));
        end
      end
      ST_LOAD: state_d = ST_DIV;
      ST_DIV: begin
        if (div_done) begin
          accuracy_d  = quotient[ACC_W-1:0];
          acc_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (result_valid && !result_ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      correct_q   <= '0;
      invalid_q   <= '0;
      accuracy_q  <= '0;
      acc_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      correct_q   <= correct_d;
      invalid_q   <= invalid_d;
      accuracy_q  <= accuracy_d;
      acc_valid_q <= acc_valid_d;
      overrun_q   <= overrun_d;
      all_done_q  <= all_done_d;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the per-class arrays are statistics that clear must zero, so they are reset unlike a plain data memory.
    if (flush) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        seen_q[i] <= '0;
        hits_q[i] <= '0;
      end
    end else if (accept && exp_ok) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (exp_idx == i) begin
          seen_q[i] <= sat_inc(seen_q[i]);
          if (hit) hits_q[i] <= sat_inc(hits_q[i]);
        end
      end
    end
  end

  always_comb begin
    class_seen = '0;
    class_hits = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (class_sel == SEL_W'(i)) begin
        class_seen = seen_q[i];
        class_hits = hits_q[i];
      end
    end
  end

  assign count          = count_q;
  assign correct_count  = correct_q;
  assign invalid_count  = invalid_q;
  assign accuracy       = accuracy_q;
  assign accuracy_valid = acc_valid_q;
  assign overrun        = overrun_q;
  assign all_done       = all_done_q;

endmodule

// File: tb/tb_inference_scoreboard.sv
// Randomised scoreboard bench for inference_scoreboard: a high-level model predicts counters
// and accuracy; a monitor pops expected accuracy results whenever accuracy_valid pulses.
module tb_inference_scoreboard;

  localparam int NC   = 10;
  localparam int MAXI = 200;
  localparam int FRAC = 0;
  localparam int CW   = $clog2(MAXI + 1);
  localparam int AW   = 7 + FRAC;
  localparam int SW   = $clog2(NC);
  localparam int DW   = CW + 7 + FRAC;
  localparam int LAT  = DW + 2;

  logic          clk;
  logic          rst_overall;
  logic          clear;
  logic          result_valid;
  logic          result_ready;
  logic [NC-1:0] obtained_output;
  logic [NC-1:0] expected_output;
  logic [CW-1:0] count;
  logic [CW-1:0] correct_count;
  logic [CW-1:0] invalid_count;
  logic [AW-1:0] accuracy;
  logic          accuracy_valid;
  logic          overrun;
  logic          all_done;
  logic [SW-1:0] class_sel;
  logic [CW-1:0] class_seen;
  logic [CW-1:0] class_hits;

  inference_scoreboard #(
    .NUM_CLASSES(NC),
    .MAX_INPUTS (MAXI),
    .FRAC_BITS  (FRAC)
  ) dut (
    .clk            (clk),
    .rst_overall    (rst_overall),
    .clear          (clear),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .obtained_output(obtained_output),
    .expected_output(expected_output),
    .count          (count),
    .correct_count  (correct_count),
    .invalid_count  (invalid_count),
    .accuracy       (accuracy),
    .accuracy_valid (accuracy_valid),
    .overrun        (overrun),
    .all_done       (all_done),
    .class_sel      (class_sel),
    .class_seen     (class_seen),
    .class_hits     (class_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int acc;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  int m_n, m_cor, m_inv;
  int m_seen[NC];
  int m_hits[NC];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_n = 0;
    m_cor = 0;
    m_inv = 0;
    for (int i = 0; i < NC; i++) begin
      m_seen[i] = 0;
      m_hits[i] = 0;
    end
    exp_q.delete();
  endtask

  function automatic int onehot_idx(input logic [NC-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: every accuracy_valid pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (accuracy_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_accuracy_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("accuracy", accuracy, mon_e.acc);
        check("accuracy_latency", cyc - mon_e.cyc, LAT);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!result_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!result_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_acc();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accuracy_drained", exp_q.size(), 0);
  endtask

  task automatic issue(input logic [NC-1:0] obt, input logic [NC-1:0] exv);
    int oi, ei, t_issue;
    bit good;
    wait_ready();
    obtained_output = obt;
    expected_output = exv;
    result_valid    = 1'b1;
    t_issue         = cyc;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    oi   = onehot_idx(obt);
    ei   = onehot_idx(exv);
    good = (oi >= 0) && (ei >= 0) && (oi == ei);
    m_n++;
    if (good) m_cor++;
    if (oi < 0 || ei < 0) m_inv++;
    if (ei >= 0) begin
      m_seen[ei]++;
      if (good) m_hits[ei]++;
    end
    exp_q.push_back('{acc: (m_cor * 100 * (1 << FRAC)) / m_n, cyc: t_issue});
    check("count", count, m_n);
    check("correct_count", correct_count, m_cor);
    check("invalid_count", invalid_count, m_inv);
    check("all_done", all_done, (m_n == MAXI) ? 1 : 0);
    check("ready_low_in_load", result_ready, 0);
  endtask

  task automatic check_class(input int sel);
    class_sel = SW'(sel);
    #1;
    check($sformatf("class_seen[%0d]", sel), class_seen, (sel < NC) ? m_seen[sel] : 0);
    check($sformatf("class_hits[%0d]", sel), class_hits, (sel < NC) ? m_hits[sel] : 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_correct"}, correct_count, 0);
    check({tag, "_invalid"}, invalid_count, 0);
    check({tag, "_accuracy"}, accuracy, 0);
    check({tag, "_acc_valid"}, accuracy_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_ready"}, result_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] o, e;
    int c, ce, mode;

    rst_overall     = 1'b1;
    clear           = 1'b0;
    result_valid    = 1'b0;
    obtained_output = '0;
    expected_output = '0;
    class_sel       = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_overall = 1'b0;
    check_zero("reset");

    // Single correct result on class 3.
    issue(10'b0000001000, 10'b0000001000);
    check_class(3);
    wait_acc();
    check("acc_single_100", accuracy, 100);

    // Two correct then one wrong: 2/3.
    do_clear();
    issue(10'b0000001000, 10'b0000001000);
    issue(10'b0000000100, 10'b0000000100);
    issue(10'b0000000001, 10'b0000000010);
    wait_acc();
    check("acc_two_of_three", accuracy, 66);

    // Non-one-hot obtained vectors are wrong and invalid.
    issue(10'b0000000000, 10'b0000100000);
    issue(10'b0000000011, 10'b0000100000);
    check("invalid_two", invalid_count, 2);
    check("correct_unchanged", correct_count, 2);
    check_class(5);
    wait_acc();

    // Pulse while dividing: ignored, overrun sticky, clear wipes everything.
    issue(10'b0000001000, 10'b0000001000);
    repeat (4) @(posedge clk);
    #1;
    result_valid = 1'b1;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    check("overrun_count_unchanged", count, m_n);
    check("overrun_set", overrun, 1);
    do_clear();
    check_zero("clear");

    // Randomised mix of correct, wrong and malformed results.
    for (int k = 0; k < 40; k++) begin
      c    = $urandom_range(0, NC - 1);
      ce   = $urandom_range(0, NC - 1);
      mode = $urandom_range(0, 9);
      e    = ($urandom_range(0, 9) == 0) ? '0 : (NC'(1) << ce);
      case (mode)
        0:       o = '0;
        1:       o = (NC'(1) << c) | (NC'(1) << ((c + 1 + $urandom_range(0, NC - 2)) % NC));
        2, 3, 4, 5: o = e;
        default: o = NC'(1) << c;
      endcase
      issue(o, e);
    end
    wait_acc();
    for (int s = 0; s < (1 << SW); s++) check_class(s);
    @(posedge clk);
    #1;

    // Full run to MAX_INPUTS with alternating correct/wrong results.
    do_clear();
    for (int k = 0; k < MAXI; k++) begin
      c = $urandom_range(0, NC - 1);
      if (k % 2 == 0) issue(NC'(1) << c, NC'(1) << c);
      else issue(NC'(1) << c, NC'(1) << ((c + 1) % NC));
    end
    wait_acc();
    check("acc_half", accuracy, 50);
    check("done_high", all_done, 1);
    check("done_ready_low", result_ready, 0);
    check("done_no_overrun_yet", overrun, 0);
    result_valid = 1'b1;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    check("extra_overrun", overrun, 1);
    check("extra_count_held", count, MAXI);

    // Reset in the middle of a division aborts it with no accuracy pulse.
    rst_overall = 1'b1;
    @(posedge clk);
    #1;
    rst_overall = 1'b0;
    model_reset();
    issue(10'b0000001000, 10'b0000001000);
    repeat (3) @(posedge clk);
    #1;
    rst_overall = 1'b1;
    @(posedge clk);
    #1;
    rst_overall = 1'b0;
    model_reset();
    check_zero("mid_div_reset");
    repeat (20) @(posedge clk);
    #1;

    // clear wins over a simultaneous result.
    obtained_output = 10'b0000001000;
    expected_output = 10'b0000001000;
    clear           = 1'b1;
    result_valid    = 1'b1;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    result_valid = 1'b0;
    check("clear_wins_count", count, 0);
    check("clear_wins_overrun", overrun, 0);
    check("clear_wins_ready", result_ready, 1);
    repeat (20) @(posedge clk);
    #1;

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
